// File: rtl/pc_seq_ctrl_pkg.sv
// Shared constants and state encoding for the PC sequencer.
// Imported by pc_seq_ctrl and pc_redirect_buf.
package pc_seq_ctrl_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        RstDisable  = 1'b0;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_RST   = 2'b00,
    S_FETCH = 2'b01,
    S_HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry pending-redirect register. An exception always wins the entry;
// a branch may only replace an empty entry or an older pending branch.
module pc_redirect_buf
  import pc_seq_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         exc_valid_i,
  input  logic [W-1:0] exc_addr_i,
  input  logic         br_valid_i,
  input  logic [W-1:0] br_addr_i,
  output logic         pend_valid_o,
  output logic         pend_is_exc_o,
  output logic [W-1:0] pend_addr_o
);

  logic         valid_q, valid_d;
  logic         is_exc_q, is_exc_d;
  logic [W-1:0] addr_q, addr_d;

  // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d  = valid_q;
    is_exc_d = is_exc_q;
    addr_d   = addr_q;
    if (clr_i) begin
      valid_d  = 1'b0;
      is_exc_d = 1'b0;
    end else if (exc_valid_i) begin
      valid_d  = 1'b1;
      is_exc_d = 1'b1;
      addr_d   = exc_addr_i;
    end else if (br_valid_i && !(valid_q && is_exc_q)) begin
      valid_d  = 1'b1;
      is_exc_d = 1'b0;
      addr_d   = br_addr_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_q  <= 1'b0;
      is_exc_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      is_exc_q <= is_exc_d;
      addr_q   <= addr_d;
    end
  end

  assign pend_valid_o  = valid_q;
  assign pend_is_exc_o = is_exc_q;
  assign pend_addr_o   = addr_q;

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencer: advance/redirect/flush decisions with one buffered redirect.
// Optional branch delay slot behaviour is enabled by defining BRANCH_DELAY_SLOT_EN.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int EXC_VEC_W  = 32,
  parameter int RST_SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_req_id,
  input  logic                 stall_req_ex,
  input  logic                 branch_valid,
  input  logic [EXC_VEC_W-1:0] branch_target,
  input  logic                 exc_valid,
  input  logic [EXC_VEC_W-1:0] exc_vector,
  input  logic                 imem_ack,
  output logic                 imem_req,
  output logic                 pc_ce,
  output logic                 jump_reg,
  output logic [EXC_VEC_W-1:0] jump_addr,
  output logic                 flush_if,
  output logic                 stall_out,
  output logic                 pend_valid
);

  localparam logic [1:0]           SettleLast = 2'(RST_SETTLE - 1);
  localparam logic [EXC_VEC_W-1:0] NoAddr     = EXC_VEC_W'(ZeroWord);

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 adv, stalled;
  logic                 buf_valid, buf_is_exc;
  logic [EXC_VEC_W-1:0] buf_addr;
  logic                 hit, is_br;
  logic [EXC_VEC_W-1:0] sel_addr;

  assign stalled = stall_req_id | stall_req_ex;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adv       = 1'b0;
    imem_req  = 1'b0;
    stall_out = 1'b0;
    case (state_q)
      S_RST: begin
        if (cnt_q == SettleLast) state_d = S_FETCH;
        else                     cnt_d   = cnt_q + 2'd1;
      end
      S_FETCH: begin
        imem_req  = 1'b1;
        adv       = imem_ack & ~stalled;
        stall_out = stalled | ~imem_ack;
        if (imem_ack && stalled) state_d = S_HOLD;
      end
      S_HOLD: begin
        // Word already captured: release advances without a fresh ack.
        stall_out = stalled;
        if (!stalled) begin
          adv     = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_RST;
    endcase
    if (rst == RstEnable) begin
      adv       = 1'b0;
      imem_req  = 1'b0;
      stall_out = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= S_RST;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Redirect priority: live exception, pending exception, live branch, pending branch.
  always_comb begin
    hit      = 1'b0;
    is_br    = 1'b0;
    sel_addr = NoAddr;
    if (exc_valid) begin
      hit      = 1'b1;
      sel_addr = exc_vector;
    end else if (buf_valid && buf_is_exc) begin
      hit      = 1'b1;
      sel_addr = buf_addr;
    end else if (branch_valid) begin
      hit      = 1'b1;
      is_br    = 1'b1;
      sel_addr = branch_target;
    end else if (buf_valid) begin
      hit      = 1'b1;
      is_br    = 1'b1;
      sel_addr = buf_addr;
    end
  end

  pc_redirect_buf #(.W(EXC_VEC_W)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (adv),
    .exc_valid_i  (exc_valid & ~adv),
    .exc_addr_i   (exc_vector),
    .br_valid_i   (branch_valid & ~adv),
    .br_addr_i    (branch_target),
    .pend_valid_o (buf_valid),
    .pend_is_exc_o(buf_is_exc),
    .pend_addr_o  (buf_addr)
  );

  assign pc_ce      = adv ? ChipEnable : ChipDisable;
  assign pend_valid = (rst == RstEnable) ? 1'b0 : buf_valid;

`ifdef BRANCH_DELAY_SLOT_EN
  logic                 slot_armed_q, slot_armed_d;
  logic [EXC_VEC_W-1:0] slot_addr_q, slot_addr_d;
  logic                 exc_win;

  assign exc_win = hit & ~is_br;

  // A branch winner only arms the slot; the armed target is taken at the next advance.
  always_comb begin
    slot_armed_d = slot_armed_q;
    slot_addr_d  = slot_addr_q;
    if (adv) begin
      slot_armed_d = hit & is_br;
      slot_addr_d  = sel_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      slot_armed_q <= 1'b0;
      slot_addr_q  <= '0;
    end else begin
      slot_armed_q <= slot_armed_d;
      slot_addr_q  <= slot_addr_d;
    end
  end

  assign jump_reg  = adv & (exc_win | slot_armed_q);
  assign jump_addr = !jump_reg ? NoAddr : (exc_win ? sel_addr : slot_addr_q);
  assign flush_if  = adv & exc_win;
`else
  assign jump_reg  = adv & hit;
  assign jump_addr = jump_reg ? sel_addr : NoAddr;
  assign flush_if  = jump_reg;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed self-checking bench for pc_seq_ctrl (default build, RST_SETTLE=1).
module tb_pc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_id, stall_req_ex;
  logic        branch_valid, exc_valid, imem_ack;
  logic [31:0] branch_target, exc_vector;
  logic        imem_req, pc_ce, jump_reg, flush_if, stall_out, pend_valid;
  logic [31:0] jump_addr;
  logic [31:0] pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_seq_ctrl #(.EXC_VEC_W(32), .RST_SETTLE(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req_id (stall_req_id),
    .stall_req_ex (stall_req_ex),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .exc_valid    (exc_valid),
    .exc_vector   (exc_vector),
    .imem_ack     (imem_ack),
    .imem_req     (imem_req),
    .pc_ce        (pc_ce),
    .jump_reg     (jump_reg),
    .jump_addr    (jump_addr),
    .flush_if     (flush_if),
    .stall_out    (stall_out),
    .pend_valid   (pend_valid)
  );

  // PC register that the sequencer drives.
  always @(posedge clk) begin
    if (rst) pc <= 32'h0;
    else if (pc_ce) pc <= jump_reg ? jump_addr : pc + 32'd4;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    outs = {imem_req, pc_ce, jump_reg, flush_if, stall_out, pend_valid, jump_addr};
    n_cmp++;
    if (outs !== 38'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({imem_req, pc_ce} !== 2'b00) begin
      n_bad++;
      $display("FAIL settle_cycle: req/ce got %b expected 00", {imem_req, pc_ce});
    end
    next_cycle();
  endtask

  task automatic test_walk();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({imem_req, pc_ce, jump_reg, pc} !== {3'b110, 32'(i * 4)}) begin
        n_bad++;
        $display("FAIL walk_%0d: req/ce/jr/pc got %b%b%b %h expected 110 %h",
                 i, imem_req, pc_ce, jump_reg, pc, 32'(i * 4));
      end
      next_cycle();
    end
  endtask

  task automatic test_branch();
    branch_valid = 1'b1; branch_target = 32'h100;
    @(negedge clk);
    n_cmp++;
    if ({pc_ce, jump_reg, flush_if, jump_addr} !== {3'b111, 32'h100}) begin
      n_bad++;
      $display("FAIL branch_live: ce/jr/fl/addr got %b%b%b %h expected 111 100",
               pc_ce, jump_reg, flush_if, jump_addr);
    end
    next_cycle();
    branch_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pc, jump_reg, flush_if} !== {32'h100, 2'b00}) begin
      n_bad++;
      $display("FAIL branch_pc: pc/jr/fl got %h %b%b expected 100 00", pc, jump_reg, flush_if);
    end
    next_cycle();
  endtask

  task automatic test_stall_pending();
    stall_req_ex = 1'b1; branch_valid = 1'b1; branch_target = 32'h200;
    @(negedge clk);
    n_cmp++;
    if ({pc_ce, jump_reg, stall_out} !== 3'b001) begin
      n_bad++;
      $display("FAIL stall_c1: ce/jr/so got %b%b%b expected 001", pc_ce, jump_reg, stall_out);
    end
    next_cycle();
    branch_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({pc_ce, pend_valid, imem_req, stall_out} !== 4'b0101) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: ce/pv/req/so got %b%b%b%b expected 0101",
                 i, pc_ce, pend_valid, imem_req, stall_out);
      end
      next_cycle();
    end
    stall_req_ex = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pc_ce, jump_reg, flush_if, jump_addr} !== {3'b111, 32'h200}) begin
      n_bad++;
      $display("FAIL stall_release: ce/jr/fl/addr got %b%b%b %h expected 111 200",
               pc_ce, jump_reg, flush_if, jump_addr);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({pend_valid, pc_ce, jump_reg, pc} !== {3'b010, 32'h200}) begin
      n_bad++;
      $display("FAIL stall_after: pv/ce/jr/pc got %b%b%b %h expected 010 200",
               pend_valid, pc_ce, jump_reg, pc);
    end
    next_cycle();
  endtask

  task automatic test_exc_override();
    stall_req_id = 1'b1; branch_valid = 1'b1; branch_target = 32'h200;
    next_cycle();
    branch_valid = 1'b0; exc_valid = 1'b1; exc_vector = 32'h180;
    @(negedge clk);
    n_cmp++;
    if ({pc_ce, pend_valid} !== 2'b01) begin
      n_bad++;
      $display("FAIL exc_held: ce/pv got %b%b expected 01", pc_ce, pend_valid);
    end
    next_cycle();
    exc_valid = 1'b0; branch_valid = 1'b1; branch_target = 32'h300;
    next_cycle();
    branch_valid = 1'b0; stall_req_id = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pc_ce, jump_reg, jump_addr} !== {2'b11, 32'h180}) begin
      n_bad++;
      $display("FAIL exc_release: ce/jr/addr got %b%b %h expected 11 180", pc_ce, jump_reg, jump_addr);
    end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    stall_req_ex = 1'b1;
    exc_valid = 1'b1; exc_vector = 32'h1C0;
    branch_valid = 1'b1; branch_target = 32'h2C0;
    next_cycle();
    exc_valid = 1'b0; branch_valid = 1'b0; stall_req_ex = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({jump_reg, jump_addr} !== {1'b1, 32'h1C0}) begin
      n_bad++;
      $display("FAIL simul_exc_br: jr/addr got %b %h expected 1 1c0", jump_reg, jump_addr);
    end
    next_cycle();
    // Live exception on the release cycle beats a pending branch.
    stall_req_ex = 1'b1; branch_valid = 1'b1; branch_target = 32'h240;
    next_cycle();
    branch_valid = 1'b0; stall_req_ex = 1'b0; exc_valid = 1'b1; exc_vector = 32'h1A0;
    @(negedge clk);
    n_cmp++;
    if ({jump_reg, jump_addr} !== {1'b1, 32'h1A0}) begin
      n_bad++;
      $display("FAIL live_exc_vs_pend: jr/addr got %b %h expected 1 1a0", jump_reg, jump_addr);
    end
    next_cycle();
    exc_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pend_valid, jump_reg, pc} !== {2'b00, 32'h1A0}) begin
      n_bad++;
      $display("FAIL superseded_clear: pv/jr/pc got %b%b %h expected 00 1a0", pend_valid, jump_reg, pc);
    end
    next_cycle();
  endtask

  task automatic test_ack_wait();
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({imem_req, pc_ce, stall_out} !== 3'b101) begin
        n_bad++;
        $display("FAIL ack_wait_%0d: req/ce/so got %b%b%b expected 101", i, imem_req, pc_ce, stall_out);
      end
      next_cycle();
    end
    imem_ack = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pc_ce, stall_out} !== 2'b10) begin
      n_bad++;
      $display("FAIL ack_arrive: ce/so got %b%b expected 10", pc_ce, stall_out);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_pending();
    stall_req_ex = 1'b1; branch_valid = 1'b1; branch_target = 32'h3C0;
    next_cycle();
    branch_valid = 1'b0; stall_req_ex = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pend_valid, pc_ce, jump_reg, imem_req} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_mid: pv/ce/jr/req got %b%b%b%b expected 0000", pend_valid, pc_ce, jump_reg, imem_req);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({pend_valid, pc_ce, jump_reg, pc} !== {3'b010, 32'h0}) begin
      n_bad++;
      $display("FAIL rst_discard: pv/ce/jr/pc got %b%b%b %h expected 010 0",
               pend_valid, pc_ce, jump_reg, pc);
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    stall_req_id = 1'b0; stall_req_ex = 1'b0;
    branch_valid = 1'b0; branch_target = 32'h0;
    exc_valid = 1'b0; exc_vector = 32'h0;
    imem_ack = 1'b1;
    test_reset();
    test_walk();
    test_branch();
    test_stall_pending();
    test_exc_override();
    test_simultaneous();
    test_ack_wait();
    test_reset_mid_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
